ex_mdu: RTL and testbench
=========================

Name: ex_mdu

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- It is started by the decoded mul/div flag and consumes the latched source operands.
- It raises a stall that drives the ID/EX and upstream suspend inputs until the result is ready.
- It returns a 32-bit result to the EX writeback mux on a single-cycle done pulse.

Parameters:
- DIV_ZERO_FAST, 1: 1 = a zero divisor skips the iteration loop (done 2 cycles after accept); 0 = it runs the full iteration loop.

Ports:
- cpu_clk  in  1  clock; all state changes on the rising edge.
- cpu_rstn  in  1  reset, asynchronous and active-low.
- start  in  1  a mul/div instruction is present in EX (ID/EX mulordiv_out & valid_out); held high while stalled.
- flush  in  1  EX instruction is being squashed (branch mispredict or exception).
- op  in  3  0 MUL, 1 MULH, 2 MULHU, 3 DIV, 4 MOD, 5 DIVU, 6 MODU, 7 reserved.
- src_a  in  32  rs1 / dividend.
- src_b  in  32  rs2 / divisor.
- stall  out  1  hold the pipeline (feeds the suspend inputs).
- busy  out  1  an operation is in flight (state not IDLE and not DONE).
- done  out  1  single-cycle pulse; result is valid this cycle.
- result  out  32  operation result; held until the next accept.

Behaviour:
- Reset (async, cpu_rstn=0): state=IDLE, busy=0, done=0, result=0, internal registers=0. stall is forced to 0 while in reset.
- States: IDLE, MUL, DIV, FIX, DONE.
- Accept happens in IDLE when start=1 and flush=0. On accept, op, src_a and src_b are latched.
  - op 0-2 go to MUL.
  - op 3-6 with src_b≠0 go to DIV; the counter is loaded with 31.
  - op 3-6 with src_b=0 and DIV_ZERO_FAST=1 go straight to FIX.
  - op 7 goes to DONE with result=0.
- MUL: one cycle, then DONE.
  - Forms the 64-bit product: signed×signed for ops 0/1, unsigned×unsigned for op 2.
  - result = product[31:0] for MUL, product[63:32] for MULH/MULHU.
- DIV: radix-2 restoring division on magnitudes; signed ops use |a| and |b|, unsigned ops use a and b directly.
  - Each cycle performs one quotient bit and decrements the counter.
  - After the counter=0 cycle the state moves to FIX, so DIV lasts 32 cycles.
- FIX: applies signs, then DONE.
  - Quotient is negated when sign(a)≠sign(b) (signed ops only).
  - Remainder takes the sign of the dividend.
  - Divide by zero: quotient=0xFFFFFFFF, remainder=src_a, for both signed and unsigned ops.
  - Signed overflow 0x80000000/0xFFFFFFFF: quotient=0x80000000, remainder=0. This falls out of the magnitude algorithm and needs no special case.
- DONE: done=1 and result is valid; return to IDLE next cycle.
  - start is ignored in DONE, so the held instruction is not retriggered.
- stall = (IDLE & start & ~flush) | MUL | DIV | FIX.
  - stall is 0 in DONE so ID/EX advances that edge.
- Latency from the accept edge: done is high in the 2nd cycle for MUL ops, the 34th cycle for DIV ops, and the 2nd cycle for divide-by-zero with the fast path.
- flush has priority in every state.
  - In MUL/DIV/FIX/DONE: next state is IDLE, done is not asserted, result is unchanged.
  - flush and start together in IDLE: no accept.
- Operands are sampled only at accept; src changes while busy are ignored.
- Async reset mid-operation: immediate return to IDLE with all outputs 0.
- A new accept may occur in the cycle after DONE; back-to-back operations are supported.

Test Plan:
- MUL 0xFFFFFFFE × 0x00000003, start held -> stall for 2 cycles, done in cycle 2, result=0xFFFFFFFA. MULH on the same operands -> 0xFFFFFFFF. MULHU on the same operands -> 0x00000002.
- DIV 0xFFFFFFF9 (-7) / 2 -> done at cycle 34, result=0xFFFFFFFD. MOD on the same operands -> 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- DIV 0x80000000 / 0xFFFFFFFF -> result=0x80000000. MOD on the same operands -> 0x00000000.
- DIVU 0x12345678 / 0 -> done at cycle 2, result=0xFFFFFFFF. MODU on the same operands -> 0x12345678. Repeat with DIV_ZERO_FAST=0 -> done at cycle 34 with the same values.
- Start a DIV, pulse flush at cycle 10 -> state returns to IDLE, stall=0 next cycle, done never asserts, result keeps its prior value.
- Start a DIV, pull cpu_rstn low at cycle 5 asynchronously -> busy, done, stall and result go to 0 immediately. Then run back-to-back MUL,DIV with start held -> exactly one done per instruction.

Source files
------------

// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - iterative multiply/divide unit for the EX stage
module ex_mdu #(
    parameter bit DIV_ZERO_FAST = 1'b1
) (
    input  logic        cpu_clk,
    input  logic        cpu_rstn,
    input  logic        start,
    input  logic        flush,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MULH  = 3'd1;
    localparam logic [2:0] OP_MULHU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_MOD   = 3'd4;
    localparam logic [2:0] OP_MODU  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t      state;
    logic [2:0]  op_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvs;
    logic [4:0]  cnt;
    logic        done_r;

    // Divider works on magnitudes; operand signs are kept in a_r/b_r for FIX.
    logic        in_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    always_comb begin
        in_signed = (op == OP_DIV) || (op == OP_MOD);
        a_mag     = (in_signed && src_a[31]) ? (~src_a + 32'd1) : src_a;
        b_mag     = (in_signed && src_b[31]) ? (~src_b + 32'd1) : src_b;
    end

    logic        mul_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;
    logic [31:0] mul_result;

    always_comb begin
        mul_signed = (op_r == OP_MUL) || (op_r == OP_MULH);
        mul_a      = {{32{mul_signed & a_r[31]}}, a_r};
        mul_b      = {{32{mul_signed & b_r[31]}}, b_r};
        product    = mul_a * mul_b;
        mul_result = (op_r == OP_MUL) ? product[31:0] : product[63:32];
    end

    // One restoring step: the remainder stays below the divisor, so the
    // subtraction result always fits back into 32 bits.
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [31:0] rem_next;
    logic [31:0] quo_next;

    always_comb begin
        rem_shift = {rem, quo[31]};
        rem_ge    = (rem_shift >= {1'b0, dvs});
        rem_next  = rem_ge ? (rem_shift[31:0] - dvs) : rem_shift[31:0];
        quo_next  = {quo[30:0], rem_ge};
    end

    logic        div_signed;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] fix_result;

    always_comb begin
        div_signed = (op_r == OP_DIV) || (op_r == OP_MOD);
        quo_fix    = (div_signed && (a_r[31] ^ b_r[31])) ? (~quo + 32'd1) : quo;
        rem_fix    = (div_signed && a_r[31]) ? (~rem + 32'd1) : rem;
        if (b_r == 32'd0) begin
            quo_fix = 32'hFFFF_FFFF;
            rem_fix = a_r;
        end
        fix_result = ((op_r == OP_MOD) || (op_r == OP_MODU)) ? rem_fix : quo_fix;
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state  <= S_IDLE;
            op_r   <= 3'd0;
            a_r    <= 32'd0;
            b_r    <= 32'd0;
            quo    <= 32'd0;
            rem    <= 32'd0;
            dvs    <= 32'd0;
            cnt    <= 5'd0;
            busy   <= 1'b0;
            done_r <= 1'b0;
            result <= 32'd0;
        end else begin
            done_r <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            op_r <= op;
                            a_r  <= src_a;
                            b_r  <= src_b;
                            quo  <= a_mag;
                            rem  <= 32'd0;
                            dvs  <= b_mag;
                            cnt  <= 5'd31;
                            if (op <= OP_MULHU) begin
                                state <= S_MUL;
                                busy  <= 1'b1;
                            end else if (op == OP_RSVD) begin
                                state  <= S_DONE;
                                result <= 32'd0;
                                done_r <= 1'b1;
                            end else if (DIV_ZERO_FAST && (src_b == 32'd0)) begin
                                state <= S_FIX;
                                busy  <= 1'b1;
                            end else begin
                                state <= S_DIV;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    S_MUL: begin
                        result <= mul_result;
                        state  <= S_DONE;
                        busy   <= 1'b0;
                        done_r <= 1'b1;
                    end
                    S_DIV: begin
                        quo <= quo_next;
                        rem <= rem_next;
                        cnt <= cnt - 5'd1;
                        if (cnt == 5'd0) begin
                            state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        result <= fix_result;
                        state  <= S_DONE;
                        busy   <= 1'b0;
                        done_r <= 1'b1;
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // DONE deliberately drops stall so ID/EX advances on that edge.
    assign stall = cpu_rstn & (((state == S_IDLE) & start & ~flush) |
                               (state == S_MUL) | (state == S_DIV) | (state == S_FIX));
    assign done  = done_r & ~flush;

endmodule

// File: tb/tb_ex_mdu.sv
// tb/tb_ex_mdu.sv - self-checking bench for ex_mdu
module tb_ex_mdu;
    logic        cpu_clk = 1'b0;
    logic        cpu_rstn = 1'b0;
    logic        start_f = 1'b0;
    logic        start_s = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        stall_f, busy_f, done_f;
    logic        stall_s, busy_s, done_s;
    logic [31:0] result_f, result_s;

    int          vectors = 0;
    int          miscompares = 0;
    bit          in_done = 1'b0;
    logic [31:0] last_exp_f = 32'd0;

    always #5 cpu_clk = ~cpu_clk;

    ex_mdu #(.DIV_ZERO_FAST(1'b1)) dut_f (
        .cpu_clk (cpu_clk),
        .cpu_rstn(cpu_rstn),
        .start   (start_f),
        .flush   (flush),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .stall   (stall_f),
        .busy    (busy_f),
        .done    (done_f),
        .result  (result_f)
    );

    ex_mdu #(.DIV_ZERO_FAST(1'b0)) dut_s (
        .cpu_clk (cpu_clk),
        .cpu_rstn(cpu_rstn),
        .start   (start_s),
        .flush   (flush),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .stall   (stall_s),
        .busy    (busy_s),
        .done    (done_s),
        .result  (result_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        p  = 64'd0;
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = ua * ub; return p[63:32]; end
            3'd3: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd4: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 0) return a; return a % b; end
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] b, input bit fast);
        if (o == 3'd7) return 1;
        if (o <= 3'd2) return 2;
        if (b == 0 && fast) return 2;
        return 34;
    endfunction

    // Called at a negedge with the DUT idle, or in its DONE cycle when in_done is set.
    task automatic run(input bit slow, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit keep, input string tag);
        int          exp_lat;
        int          got;
        logic [31:0] exp_res;
        exp_res = ref_result(o, a, b);
        exp_lat = ref_lat(o, b, !slow);
        op = o;
        src_a = a;
        src_b = b;
        if (slow) start_s = 1'b1; else start_f = 1'b1;
        if (in_done) @(negedge cpu_clk);
        #1 chk($sformatf("%s stall_pre", tag), 32'(slow ? stall_s : stall_f), 32'd1);
        got = 0;
        for (int c = 1; c <= 40 && got == 0; c++) begin
            @(negedge cpu_clk);
            if ((slow ? done_s : done_f) === 1'b1) begin
                got = c;
            end else begin
                chk($sformatf("%s stall_run c%0d", tag, c), 32'(slow ? stall_s : stall_f), 32'd1);
                op = 3'($urandom_range(0, 7));
                src_a = $urandom;
                src_b = $urandom;
            end
        end
        chk($sformatf("%s latency", tag), got, exp_lat);
        if (got != 0) begin
            chk($sformatf("%s result", tag), slow ? result_s : result_f, exp_res);
            chk($sformatf("%s stall_done", tag), 32'(slow ? stall_s : stall_f), 32'd0);
            chk($sformatf("%s busy_done", tag), 32'(slow ? busy_s : busy_f), 32'd0);
        end
        if (!slow) last_exp_f = exp_res;
        if (keep) begin
            in_done = 1'b1;
        end else begin
            if (slow) start_s = 1'b0; else start_f = 1'b0;
            @(negedge cpu_clk);
            chk($sformatf("%s done_single", tag), 32'(slow ? done_s : done_f), 32'd0);
            chk($sformatf("%s busy_after", tag), 32'(slow ? busy_s : busy_f), 32'd0);
            in_done = 1'b0;
        end
    endtask

    initial begin
        int          nd;
        bit          kp;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        start_f = 1'b1;
        #12;
        chk("reset stall", 32'(stall_f), 32'd0);
        chk("reset busy", 32'(busy_f), 32'd0);
        chk("reset done", 32'(done_f), 32'd0);
        chk("reset result", result_f, 32'd0);
        start_f = 1'b0;
        @(negedge cpu_clk);
        cpu_rstn = 1'b1;

        run(0, 3'd0, 32'hFFFF_FFFE, 32'h3, 0, "mul");
        run(0, 3'd1, 32'hFFFF_FFFE, 32'h3, 0, "mulh");
        run(0, 3'd2, 32'hFFFF_FFFE, 32'h3, 0, "mulhu");
        run(0, 3'd3, 32'hFFFF_FFF9, 32'h2, 0, "div");
        run(0, 3'd4, 32'hFFFF_FFF9, 32'h2, 0, "mod");
        run(0, 3'd5, 32'hFFFF_FFF9, 32'h2, 0, "divu");
        run(0, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
        run(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "mod_ovf");
        run(0, 3'd5, 32'h1234_5678, 32'h0, 0, "divu_z_fast");
        run(0, 3'd6, 32'h1234_5678, 32'h0, 0, "modu_z_fast");
        run(0, 3'd3, 32'h8765_4321, 32'h0, 0, "div_z_fast");
        run(0, 3'd4, 32'h8765_4321, 32'h0, 0, "mod_z_fast");
        run(0, 3'd7, 32'h1111_2222, 32'h3, 0, "rsvd");
        run(1, 3'd5, 32'h1234_5678, 32'h0, 0, "divu_z_slow");
        run(1, 3'd6, 32'h1234_5678, 32'h0, 0, "modu_z_slow");
        run(1, 3'd4, 32'h8765_4321, 32'h0, 0, "mod_z_slow");

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 10);
                2: rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            kp = (i != 23) && ($urandom_range(0, 1) == 1);
            run(0, ro, ra, rb, kp, $sformatf("rnd_f%0d", i));
        end
        for (int i = 0; i < 6; i++) begin
            ro = 3'($urandom_range(3, 6));
            ra = $urandom;
            rb = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
            run(1, ro, ra, rb, 0, $sformatf("rnd_s%0d", i));
        end

        op = 3'd3;
        src_a = 32'h1234_5678;
        src_b = 32'd7;
        start_f = 1'b1;
        repeat (10) @(negedge cpu_clk);
        flush = 1'b1;
        start_f = 1'b0;
        #1 chk("flush done_gate", 32'(done_f), 32'd0);
        @(negedge cpu_clk);
        flush = 1'b0;
        #1;
        chk("flush stall", 32'(stall_f), 32'd0);
        chk("flush busy", 32'(busy_f), 32'd0);
        chk("flush result_kept", result_f, last_exp_f);
        nd = 0;
        repeat (40) begin
            @(negedge cpu_clk);
            if (done_f === 1'b1) nd++;
        end
        chk("flush no_done", nd, 32'd0);

        op = 3'd3;
        src_a = 32'hFFFF_FF00;
        src_b = 32'd3;
        start_f = 1'b1;
        repeat (5) @(negedge cpu_clk);
        #2 cpu_rstn = 1'b0;
        #1;
        chk("arst busy", 32'(busy_f), 32'd0);
        chk("arst done", 32'(done_f), 32'd0);
        chk("arst stall", 32'(stall_f), 32'd0);
        chk("arst result", result_f, 32'd0);
        @(negedge cpu_clk);
        start_f = 1'b0;
        cpu_rstn = 1'b1;
        in_done = 1'b0;

        run(0, 3'd0, 32'h0001_0003, 32'h0000_0005, 1, "b2b_mul");
        run(0, 3'd3, 32'h0000_0064, 32'hFFFF_FFF9, 1, "b2b_div");
        run(0, 3'd6, 32'h0000_0064, 32'h0000_0007, 0, "b2b_modu");
        nd = 0;
        repeat (5) begin
            @(negedge cpu_clk);
            if (done_f === 1'b1) nd++;
        end
        chk("b2b no_extra_done", nd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
